debug_mem_sequencer: RTL and testbench

//  Synthesizable load/run/dump controller for RV32Core's debug RAM ports (A2/WD2/WE2/RD2).

---
 rtl/debug_mem_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_debug_mem_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_mem_sequencer.sv
// debug_mem_sequencer
//   Load/run/dump controller for RV32Core's debug RAM ports (A2/WD2/WE2/RD2).
//   Streams host words into InstRAM then DataRAM while holding the core in
//   reset, releases the core for RUN_CYCLES cycles, then freezes it and
//   streams DataRAM words 0..DUMP_WORDS-1 back to the host.
//
// Ports
//   CPU_CLK, CPU_RST_N          clock, asynchronous active-low reset
//   start                       restart pulse, honoured in IDLE/DONE only
//   inst_words, data_words      word counts, latched (clamped) on start
//   in_valid/in_ready/in_data   load stream (inst words, then data words)
//   out_valid/out_ready/out_data dump stream of DataRAM words
//   core_rst                    RV32Core CPU_RST (active high)
//   dram_a2/wd2/we2, dram_rd2   DataRAM debug port (rd2: 1-cycle sync read)
//   iram_a2/wd2/we2             InstRAM debug port
//   busy, done                  status; every output is registered
module debug_mem_sequencer #(
    parameter int unsigned BRAMWORDS  = 4096,
    parameter int unsigned RST_CYCLES = 5,
    parameter int unsigned RUN_CYCLES = 200000,
    parameter int unsigned DUMP_WORDS = 4096
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST_N,
    input  logic        start,
    input  logic [12:0] inst_words,
    input  logic [12:0] data_words,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        core_rst,
    output logic [31:0] dram_a2,
    output logic [31:0] dram_wd2,
    output logic [3:0]  dram_we2,
    input  logic [31:0] dram_rd2,
    output logic [31:0] iram_a2,
    output logic [31:0] iram_wd2,
    output logic [3:0]  iram_we2,
    output logic        busy,
    output logic        done
);

    localparam int unsigned IW   = $clog2(BRAMWORDS + 1);
    localparam int unsigned CMAX = (RUN_CYCLES > RST_CYCLES) ? RUN_CYCLES : RST_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_I, S_LOAD_D, S_RST_HOLD, S_RUN, S_DUMP, S_DONE
    } state_t;

    state_t         r_state,     w_state;
    logic [IW-1:0]  r_icnt,      w_icnt;
    logic [IW-1:0]  r_dcnt,      w_dcnt;
    logic [IW-1:0]  r_idx,       w_idx;
    logic [CW-1:0]  r_cyc,       w_cyc;
    logic           r_dwait,     w_dwait;
    logic           r_in_ready,  w_in_ready;
    logic           r_out_valid, w_out_valid;
    logic [31:0]    r_out_data,  w_out_data;
    logic           r_core_rst,  w_core_rst;
    logic [31:0]    r_dram_a2,   w_dram_a2;
    logic [31:0]    r_dram_wd2,  w_dram_wd2;
    logic [3:0]     r_dram_we2,  w_dram_we2;
    logic [31:0]    r_iram_a2,   w_iram_a2;
    logic [31:0]    r_iram_wd2,  w_iram_wd2;
    logic [3:0]     r_iram_we2,  w_iram_we2;
    logic           r_busy,      w_busy;
    logic           r_done,      w_done;

    logic           w_hs;
    logic [31:0]    w_idx_addr;
    logic [IW-1:0]  w_inst_clamp;
    logic [IW-1:0]  w_data_clamp;
    logic           w_dump_last;

    always_comb begin
        w_state     = r_state;
        w_icnt      = r_icnt;
        w_dcnt      = r_dcnt;
        w_idx       = r_idx;
        w_cyc       = r_cyc;
        w_dwait     = r_dwait;
        w_out_valid = r_out_valid;
        w_out_data  = r_out_data;
        w_dram_a2   = r_dram_a2;
        w_dram_wd2  = r_dram_wd2;
        w_dram_we2  = '0;
        w_iram_a2   = r_iram_a2;
        w_iram_wd2  = r_iram_wd2;
        w_iram_we2  = '0;

        w_hs         = in_valid & r_in_ready;
        w_idx_addr   = 32'(r_idx) << 2;
        w_inst_clamp = (32'(inst_words) > BRAMWORDS) ? IW'(BRAMWORDS) : IW'(inst_words);
        w_data_clamp = (32'(data_words) > BRAMWORDS) ? IW'(BRAMWORDS) : IW'(data_words);
        w_dump_last  = (r_idx == IW'(DUMP_WORDS - 1));

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_icnt = w_inst_clamp;
                    w_dcnt = w_data_clamp;
                    w_idx  = '0;
                    w_cyc  = '0;
                    if (w_inst_clamp != '0)      w_state = S_LOAD_I;
                    else if (w_data_clamp != '0) w_state = S_LOAD_D;
                    else                         w_state = S_RST_HOLD;
                end
            end
            S_LOAD_I: begin
                if (w_hs) begin
                    w_iram_a2  = w_idx_addr;
                    w_iram_wd2 = in_data;
                    w_iram_we2 = '1;
                    if (r_idx == r_icnt - IW'(1)) begin
                        w_idx   = '0;
                        w_state = (r_dcnt != '0) ? S_LOAD_D : S_RST_HOLD;
                    end else begin
                        w_idx = r_idx + IW'(1);
                    end
                end
            end
            S_LOAD_D: begin
                if (w_hs) begin
                    w_dram_a2  = w_idx_addr;
                    w_dram_wd2 = in_data;
                    w_dram_we2 = '1;
                    if (r_idx == r_dcnt - IW'(1)) begin
                        w_idx   = '0;
                        w_state = S_RST_HOLD;
                    end else begin
                        w_idx = r_idx + IW'(1);
                    end
                end
            end
            S_RST_HOLD: begin
                if (r_cyc == CW'(RST_CYCLES - 1)) begin
                    w_cyc   = '0;
                    w_state = S_RUN;
                end else begin
                    w_cyc = r_cyc + CW'(1);
                end
            end
            S_RUN: begin
                if (r_cyc == CW'(RUN_CYCLES - 1)) begin
                    w_cyc     = '0;
                    w_idx     = '0;
                    w_dram_a2 = '0;
                    w_dwait   = 1'b1;
                    w_state   = S_DUMP;
                end else begin
                    w_cyc = r_cyc + CW'(1);
                end
            end
            S_DUMP: begin
                // The next word's address is issued as soon as the current word
                // is captured, so its read data is settled by the time the
                // handshake completes; this is what gives 1 word per 2 cycles
                // against a registered-read RAM. rd2 stays valid while stalled
                // because the address is held and nothing writes in DUMP.
                if (r_out_valid) begin
                    if (out_ready) begin
                        w_out_valid = 1'b0;
                        if (w_dump_last) begin
                            w_idx     = '0;
                            w_dram_a2 = '0;
                            w_state   = S_DONE;
                        end else begin
                            w_idx = r_idx + IW'(1);
                        end
                    end
                end else if (r_dwait) begin
                    w_dwait = 1'b0;
                end else begin
                    w_out_data  = dram_rd2;
                    w_out_valid = 1'b1;
                    if (!w_dump_last) begin
                        w_dram_a2 = 32'(r_idx + IW'(1)) << 2;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase

        w_in_ready = (w_state == S_LOAD_I) || (w_state == S_LOAD_D);
        w_core_rst = (w_state != S_RUN);
        w_busy     = (w_state != S_IDLE) && (w_state != S_DONE);
        w_done     = (w_state == S_DONE);
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            r_state     <= S_IDLE;
            r_icnt      <= '0;
            r_dcnt      <= '0;
            r_idx       <= '0;
            r_cyc       <= '0;
            r_dwait     <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_core_rst  <= 1'b1;
            r_dram_a2   <= '0;
            r_dram_wd2  <= '0;
            r_dram_we2  <= '0;
            r_iram_a2   <= '0;
            r_iram_wd2  <= '0;
            r_iram_we2  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_icnt      <= w_icnt;
            r_dcnt      <= w_dcnt;
            r_idx       <= w_idx;
            r_cyc       <= w_cyc;
            r_dwait     <= w_dwait;
            r_in_ready  <= w_in_ready;
            r_out_valid <= w_out_valid;
            r_out_data  <= w_out_data;
            r_core_rst  <= w_core_rst;
            r_dram_a2   <= w_dram_a2;
            r_dram_wd2  <= w_dram_wd2;
            r_dram_we2  <= w_dram_we2;
            r_iram_a2   <= w_iram_a2;
            r_iram_wd2  <= w_iram_wd2;
            r_iram_we2  <= w_iram_we2;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign core_rst  = r_core_rst;
    assign dram_a2   = r_dram_a2;
    assign dram_wd2  = r_dram_wd2;
    assign dram_we2  = r_dram_we2;
    assign iram_a2   = r_iram_a2;
    assign iram_wd2  = r_iram_wd2;
    assign iram_we2  = r_iram_we2;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_debug_mem_sequencer.sv
// tb_debug_mem_sequencer
//   Directed bench for debug_mem_sequencer with a DataRAM model
//   (registered read) and passive recording of debug-port writes.
module tb_debug_mem_sequencer;

    localparam int unsigned BW   = 4096;
    localparam int unsigned RSTC = 5;
    localparam int unsigned RUNC = 20;
    localparam int unsigned DW   = 8;

    localparam logic [31:0] T1 [5] = '{32'h13, 32'h93, 32'h113, 32'hA, 32'hB};

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST_N = 1'b0;
    logic        start = 1'b0;
    logic [12:0] inst_words = '0;
    logic [12:0] data_words = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        core_rst;
    logic [31:0] dram_a2, dram_wd2, dram_rd2;
    logic [3:0]  dram_we2;
    logic [31:0] iram_a2, iram_wd2;
    logic [3:0]  iram_we2;
    logic        busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    debug_mem_sequencer #(
        .BRAMWORDS (BW),
        .RST_CYCLES(RSTC),
        .RUN_CYCLES(RUNC),
        .DUMP_WORDS(DW)
    ) dut (
        .CPU_CLK   (CPU_CLK),
        .CPU_RST_N (CPU_RST_N),
        .start     (start),
        .inst_words(inst_words),
        .data_words(data_words),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .core_rst  (core_rst),
        .dram_a2   (dram_a2),
        .dram_wd2  (dram_wd2),
        .dram_we2  (dram_we2),
        .dram_rd2  (dram_rd2),
        .iram_a2   (iram_a2),
        .iram_wd2  (iram_wd2),
        .iram_we2  (iram_we2),
        .busy      (busy),
        .done      (done)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    // DataRAM model
    logic [31:0] dmem [BW];
    logic        preload_req = 1'b0;
    always @(posedge CPU_CLK) begin
        if (preload_req) begin
            for (int i = 0; i < int'(BW); i++) dmem[i] <= 32'(i);
        end else if (dram_we2 == 4'hF) begin
            dmem[dram_a2[13:2]] <= dram_wd2;
        end
        dram_rd2 <= dmem[dram_a2[13:2]];
    end

    // Write and core-reset recorders
    logic [31:0] iw_a[$], iw_d[$], dw_a[$], dw_d[$];
    logic [3:0]  iw_w[$], dw_w[$];
    logic        iw_r[$], dw_r[$];
    int          rst_low = 0;
    always @(negedge CPU_CLK) begin
        if (iram_we2 != 4'h0) begin
            iw_a.push_back(iram_a2); iw_d.push_back(iram_wd2);
            iw_w.push_back(iram_we2); iw_r.push_back(in_ready);
        end
        if (dram_we2 != 4'h0) begin
            dw_a.push_back(dram_a2); dw_d.push_back(dram_wd2);
            dw_w.push_back(dram_we2); dw_r.push_back(in_ready);
        end
        if (!core_rst) rst_low++;
    end

    logic [31:0] exp_dump [DW];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] stream_word(input int sel, input int i);
        if (sel == 0) return T1[i];
        return 32'hC000_0000 | 32'(i);
    endfunction

    task automatic pulse_start(input int i, input int d);
        @(negedge CPU_CLK);
        inst_words = 13'(i);
        data_words = 13'(d);
        start = 1'b1;
        @(negedge CPU_CLK);
        start = 1'b0;
    endtask

    task automatic feed(input int sel, input int n_offer, input int cycles, output int accepted);
        int ptr = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge CPU_CLK);
            if (ptr < n_offer) begin
                in_valid = 1'b1;
                in_data  = stream_word(sel, ptr);
                if (in_ready) ptr++;
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
            end
        end
        @(negedge CPU_CLK);
        in_valid = 1'b0;
        accepted = ptr;
    endtask

    task automatic set_exp_linear();
        for (int k = 0; k < int'(DW); k++) exp_dump[k] = 32'(k);
    endtask

    task automatic run_to_done(input int mode, input bit start_in_run, input int rl_base,
                               input int budget);
        int dcnt = 0;
        bit fin = 1'b0;
        bit pulsed = 1'b0;
        for (int c = 0; c < budget && !fin; c++) begin
            @(negedge CPU_CLK);
            start = 1'b0;
            if (start_in_run && !pulsed && !core_rst) begin
                inst_words = 13'd7;
                data_words = 13'd7;
                start  = 1'b1;
                pulsed = 1'b1;
            end
            out_ready = (mode == 0) ? 1'b1 : ((c % 3) == 2);
            if (out_valid) begin
                if (dcnt < int'(DW)) check("dump_data", out_data, exp_dump[dcnt]);
                else                 check("dump_overrun", 32'(dcnt), 32'(DW - 1));
                if (out_ready) dcnt++;
            end
            if (done) fin = 1'b1;
        end
        start = 1'b0;
        out_ready = 1'b0;
        check("done_reached", 32'(fin), 32'd1);
        check("dump_count", 32'(dcnt), 32'(DW));
        check("run_cycles", 32'(rst_low - rl_base), 32'(RUNC));
        check("busy_in_done", 32'(busy), 32'd0);
        check("core_rst_in_done", 32'(core_rst), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, ib, db, rl;

        // Reset state
        repeat (2) @(negedge CPU_CLK);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dram_a2", dram_a2, 32'd0);
        check("rst_iram_we2", 32'(iram_we2), 32'd0);
        preload_req = 1'b1;
        @(negedge CPU_CLK);
        preload_req = 1'b0;
        CPU_RST_N = 1'b1;

        // 1: inst=3, data=2, continuous stream
        ib = iw_a.size(); db = dw_a.size(); rl = rst_low;
        pulse_start(3, 2);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_in_ready", 32'(in_ready), 32'd1);
        feed(0, 5, 10, acc);
        check("t1_accepted", 32'(acc), 32'd5);
        check("t1_iw_count", 32'(iw_a.size() - ib), 32'd3);
        check("t1_dw_count", 32'(dw_a.size() - db), 32'd2);
        for (int i = 0; i < 3; i++) begin
            check("t1_iw_addr", iw_a[ib + i], 32'(i * 4));
            check("t1_iw_data", iw_d[ib + i], T1[i]);
            check("t1_iw_we", 32'(iw_w[ib + i]), 32'hF);
            check("t1_iw_ready", 32'(iw_r[ib + i]), 32'd1);
        end
        for (int i = 0; i < 2; i++) begin
            check("t1_dw_addr", dw_a[db + i], 32'(i * 4));
            check("t1_dw_data", dw_d[db + i], T1[3 + i]);
            check("t1_dw_we", 32'(dw_w[db + i]), 32'hF);
            check("t1_dw_ready", 32'(dw_r[db + i]), (i == 0) ? 32'd1 : 32'd0);
        end
        set_exp_linear();
        exp_dump[0] = 32'hA;
        exp_dump[1] = 32'hB;
        run_to_done(0, 1'b0, rl, 300);

        // 2: restart from DONE with empty loads
        ib = iw_a.size(); db = dw_a.size(); rl = rst_low;
        pulse_start(0, 0);
        check("t2_in_ready", 32'(in_ready), 32'd0);
        check("t2_busy", 32'(busy), 32'd1);
        run_to_done(0, 1'b0, rl, 300);
        check("t2_no_iw", 32'(iw_a.size() - ib), 32'd0);
        check("t2_no_dw", 32'(dw_a.size() - db), 32'd0);

        // 3: preloaded DataRAM, out_ready 1-of-3, start pulse during RUN
        preload_req = 1'b1;
        @(negedge CPU_CLK);
        preload_req = 1'b0;
        set_exp_linear();
        ib = iw_a.size(); rl = rst_low;
        pulse_start(0, 0);
        run_to_done(1, 1'b1, rl, 300);
        check("t3_no_iw", 32'(iw_a.size() - ib), 32'd0);

        // 4: inst_words beyond BRAMWORDS is clamped
        ib = iw_a.size(); db = dw_a.size(); rl = rst_low;
        pulse_start(5000, 0);
        feed(1, 4100, 4104, acc);
        check("t4_accepted", 32'(acc), 32'd4096);
        check("t4_iw_count", 32'(iw_a.size() - ib), 32'd4096);
        check("t4_last_addr", iw_a[iw_a.size() - 1], 32'h3FFC);
        check("t4_last_data", iw_d[iw_d.size() - 1], stream_word(1, 4095));
        check("t4_in_ready", 32'(in_ready), 32'd0);
        check("t4_no_dw", 32'(dw_a.size() - db), 32'd0);
        run_to_done(0, 1'b0, rl, 300);

        // 5a: reset in the middle of LOAD_D with a write on the port
        pulse_start(2, 4);
        in_valid = 1'b1;
        in_data  = 32'h11;
        @(negedge CPU_CLK);
        in_data  = 32'h22;
        @(negedge CPU_CLK);
        in_data  = 32'h33;
        @(negedge CPU_CLK);
        in_valid = 1'b0;
        check("t5_pre_we", 32'(dram_we2), 32'hF);
        check("t5_pre_wd", dram_wd2, 32'h33);
        CPU_RST_N = 1'b0;
        #1;
        check("t5_core_rst", 32'(core_rst), 32'd1);
        check("t5_we_dropped", 32'(dram_we2), 32'd0);
        check("t5_in_ready", 32'(in_ready), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        @(posedge CPU_CLK);
        #1;
        check("t5_mem_untouched", dmem[0], 32'd0);
        @(negedge CPU_CLK);
        CPU_RST_N = 1'b1;

        // 5b: reset while a dump word is stalled
        pulse_start(0, 0);
        out_ready = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge CPU_CLK);
            if (out_valid) break;
        end
        check("t5b_dump_valid", 32'(out_valid), 32'd1);
        check("t5b_dump_a2", dram_a2, 32'd4);
        CPU_RST_N = 1'b0;
        #1;
        check("t5b_out_valid", 32'(out_valid), 32'd0);
        check("t5b_core_rst", 32'(core_rst), 32'd1);
        check("t5b_dram_a2", dram_a2, 32'd0);
        check("t5b_busy", 32'(busy), 32'd0);
        @(negedge CPU_CLK);
        CPU_RST_N = 1'b1;

        // Clean sequence after the abort
        set_exp_linear();
        rl = rst_low;
        pulse_start(0, 0);
        run_to_done(0, 1'b0, rl, 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
